port_scheduler: RTL and testbench

PORT_SCHEDULER -- requirements
Module: port_scheduler

---
 rtl/port_scheduler_if.sv | 19 +
 rtl/port_scheduler.sv | 106 ++++++++++
 tb/tb_port_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/port_scheduler_if.sv
// port_scheduler_if: per-port bus between the input ports, the scheduler and the output buffers.
//   in_valid/in_data/in_dest : word offered by each input port, with its destination output
//   in_ready                 : grant returned to each input port
//   outp/out_ram_wr          : registered word and write strobe for each output buffer RAM
//   port_full                : output buffer has reached its capacity
interface port_scheduler_if #(
   parameter int NPORTS = 4,
   parameter int DATA_W = 32
);
   logic [NPORTS-1:0] in_valid;
   logic [DATA_W-1:0] in_data [NPORTS];
   logic [1:0]        in_dest [NPORTS];
   logic [NPORTS-1:0] in_ready;
   logic [DATA_W-1:0] outp [NPORTS];
   logic [NPORTS-1:0] out_ram_wr;
   logic [NPORTS-1:0] port_full;
   modport master (output in_valid, in_data, in_dest, input in_ready, outp, out_ram_wr, port_full);
   modport slave  (input in_valid, in_data, in_dest, output in_ready, outp, out_ram_wr, port_full);
endinterface

// File: rtl/port_scheduler.sv
// port_scheduler: 4x4 crossbar scheduler with per-output round-robin arbitration and word counting.
//   clk, reset (async, active-high), enable (run request), clear_counts (sync counter clear)
//   bus          : slave side of port_scheduler_if (inputs, grants, output strobes/data, full flags)
//   total_time   : cycles spent in RUN, saturating
//   busy         : high in RUN and DRAIN
module port_scheduler #(
   parameter int NPORTS = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear_counts,
   port_scheduler_if.slave    bus,
   output logic [31:0]        total_time,
   output logic               busy
);
   localparam int CW = $clog2(DEPTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t            state_q;
   logic [31:0]       time_q;
   logic              busy_q;
   logic [CW-1:0]     cnt_q [NPORTS];
   logic [1:0]        rr_q [NPORTS];
   logic [DATA_W-1:0] outp_q [NPORTS];
   logic [NPORTS-1:0] wr_q;
   logic [NPORTS-1:0] full_d, any_d, ready_d;
   logic [1:0]        win_d [NPORTS];
   logic [1:0]        idx;
   logic              req_ok;

   // grants only while actively running with the host still asking to run
   assign req_ok = (state_q == RUN) && enable;

   always_comb begin
      ready_d = '0;
      any_d   = '0;
      full_d  = '0;
      idx     = '0;
      for (int j = 0; j < NPORTS; j++) begin
         full_d[j] = cnt_q[j] == CW'(DEPTH);
         win_d[j]  = rr_q[j];
         // scan farthest-first so the requester nearest to rr_q overwrites the others
         for (int k = NPORTS - 1; k >= 0; k--) begin
            idx = rr_q[j] + 2'(k);
            if (bus.in_valid[idx] && bus.in_dest[idx] == 2'(j) && req_ok && !full_d[j]) begin
               win_d[j] = idx;
               any_d[j] = 1'b1;
            end
         end
         if (any_d[j]) ready_d[win_d[j]] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         time_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (enable) begin
               state_q <= RUN;
               time_q  <= '0;
               busy_q  <= 1'b1;
            end
            RUN: begin
               time_q <= time_q + {31'b0, ~&time_q};
               if (!enable) state_q <= DRAIN;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q <= '0;
         for (int j = 0; j < NPORTS; j++) begin
            cnt_q[j]  <= '0;
            rr_q[j]   <= '0;
            outp_q[j] <= '0;
         end
      end else begin
         wr_q <= any_d;
         for (int j = 0; j < NPORTS; j++) begin
            if (any_d[j]) begin
               outp_q[j] <= bus.in_data[win_d[j]];
               rr_q[j]   <= win_d[j] + 2'd1;
            end
            cnt_q[j] <= clear_counts ? CW'(any_d[j]) : cnt_q[j] + CW'(any_d[j]);
         end
      end
   end

   assign bus.in_ready   = ready_d;
   assign bus.out_ram_wr = wr_q;
   assign bus.port_full  = full_d;
   assign bus.outp       = outp_q;
   assign total_time     = time_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_port_scheduler.sv
// tb_port_scheduler: randomized and directed checks of port_scheduler against a behavioural model.
module tb_port_scheduler;
   localparam int NP = 4, DW = 32, DEPTH = 4096;
   logic clk = 1'b0, reset = 1'b0, enable = 1'b0, clear_counts = 1'b0;
   logic [31:0] total_time;
   logic busy;
   int n_vec = 0, n_err = 0;
   bit chk_en = 1'b0;

   port_scheduler_if #(.NPORTS(NP), .DATA_W(DW)) bus();
   port_scheduler #(.NPORTS(NP), .DATA_W(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear_counts(clear_counts),
      .bus(bus.slave), .total_time(total_time), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: 0=idle 1=run 2=drain
   int m_state;
   logic [31:0] m_tt;
   int m_cnt [NP];
   int m_rr [NP];
   logic [DW-1:0] m_outp [NP];
   logic [NP-1:0] m_wr;

   // winner = requester with the smallest rotational distance from the pointer
   function automatic int winner(int j);
      int best = -1, bd = NP;
      for (int i = 0; i < NP; i++)
         if (bus.in_valid[i] && int'(bus.in_dest[i]) == j && m_state == 1 && enable && m_cnt[j] < DEPTH)
            if ((i - m_rr[j] + NP) % NP < bd) begin
               bd = (i - m_rr[j] + NP) % NP;
               best = i;
            end
      return best;
   endfunction

   always @(posedge clk or posedge reset) begin
      int w;
      if (reset) begin
         m_state <= 0;
         m_tt <= 0;
         m_wr <= '0;
         for (int j = 0; j < NP; j++) begin
            m_cnt[j] <= 0;
            m_rr[j] <= 0;
            m_outp[j] <= '0;
         end
      end else begin
         for (int j = 0; j < NP; j++) begin
            w = winner(j);
            m_wr[j] <= (w >= 0);
            if (w >= 0) begin
               m_outp[j] <= bus.in_data[w];
               m_rr[j] <= (w + 1) % NP;
            end
            m_cnt[j] <= clear_counts ? int'(w >= 0) : m_cnt[j] + int'(w >= 0);
         end
         if (m_state == 0 && enable) begin
            m_state <= 1;
            m_tt <= 0;
         end else if (m_state == 1) begin
            m_tt <= (m_tt == 32'hFFFF_FFFF) ? m_tt : m_tt + 1;
            if (!enable) m_state <= 2;
         end else if (m_state == 2) m_state <= 0;
      end
   end

   always @(negedge clk) if (chk_en) begin
      logic [NP-1:0] er, pf;
      int w;
      #1;
      er = '0;
      pf = '0;
      for (int j = 0; j < NP; j++) begin
         w = winner(j);
         if (w >= 0) er[w] = 1'b1;
         pf[j] = (m_cnt[j] == DEPTH);
         chk($sformatf("outp[%0d]", j), bus.outp[j], m_outp[j]);
      end
      chk("in_ready", 32'(bus.in_ready), 32'(er));
      chk("out_ram_wr", 32'(bus.out_ram_wr), 32'(m_wr));
      chk("port_full", 32'(bus.port_full), 32'(pf));
      chk("busy", 32'(busy), 32'(m_state != 0));
      chk("total_time", total_time, m_tt);
   end

   task automatic set_in(input int i, input logic v, input logic [1:0] d, input logic [31:0] x);
      bus.in_valid[i] = v;
      bus.in_dest[i] = d;
      bus.in_data[i] = x;
   endtask

   task automatic idle_in();
      for (int i = 0; i < NP; i++) set_in(i, 1'b0, 2'd0, 32'd0);
   endtask

   task automatic rand_in();
      for (int i = 0; i < NP; i++)
         set_in(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom);
   endtask

   initial begin
      int bc;
      idle_in();
      #1 reset = 1'b1;
      chk_en = 1'b1;
      #2;
      chk("rst_time", total_time, 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      chk("rst_wr", 32'(bus.out_ram_wr), 0);
      chk("rst_full", 32'(bus.port_full), 0);
      chk("rst_outp2", bus.outp[2], 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      // single transfer, latency 1
      @(negedge clk) enable = 1'b1;
      @(negedge clk) set_in(0, 1'b1, 2'd2, 32'hA5);
      #2 chk("single_ready", 32'(bus.in_ready), 32'b0001);
      @(negedge clk) idle_in();
      #2 chk("single_wr", 32'(bus.out_ram_wr), 32'b0100);
      chk("single_outp", bus.outp[2], 32'hA5);
      // four inputs contend for output 1
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) set_in(i, 1'b1, 2'd1, 32'(c * 4 + i));
         #2 chk("rr_ready", 32'(bus.in_ready), 32'(1 << (c % 4)));
         if (c > 0) chk("rr_wr", 32'(bus.out_ram_wr), 32'b0010);
      end
      @(negedge clk) idle_in();
      #2 chk("rr_wr_last", 32'(bus.out_ram_wr), 32'b0010);
      chk("rr_outp_last", bus.outp[1], 31);
      // four parallel grants
      clear_counts = 1'b1;
      @(negedge clk) clear_counts = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) set_in(i, 1'b1, 2'(i), $urandom);
         #2 chk("par_ready", 32'(bus.in_ready), 32'hF);
      end
      @(negedge clk) idle_in();
      #2 for (int j = 0; j < NP; j++) chk("par_cnt", m_cnt[j], 5);
      chk("par_wr", 32'(bus.out_ram_wr), 32'hF);
      // fill output 0
      clear_counts = 1'b1;
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk) clear_counts = 1'b0;
         set_in(0, 1'b1, 2'd0, $urandom);
      end
      @(negedge clk) set_in(0, 1'b1, 2'd0, 32'h1234);
      #2 chk("full_flag", 32'(bus.port_full), 32'b0001);
      chk("full_stall", 32'(bus.in_ready), 0);
      @(negedge clk) clear_counts = 1'b1;
      #2 chk("full_clear_stall", 32'(bus.in_ready), 0);
      @(negedge clk) clear_counts = 1'b0;
      #2 chk("full_resume", 32'(bus.in_ready), 32'b0001);
      chk("full_cleared", 32'(bus.port_full), 0);
      @(negedge clk) idle_in();
      #2 chk("full_cnt1", m_cnt[0], 1);
      chk("full_outp", bus.outp[0], 32'h1234);
      // run timing
      enable = 1'b0;
      repeat (3) @(negedge clk);
      bc = 0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         enable = (c < 10);
         for (int i = 0; i < NP; i++) set_in(i, 1'b1, 2'($urandom_range(0, 3)), $urandom);
         #2 if (busy) bc++;
         if (c == 10) chk("time_last_wr", 32'(bus.out_ram_wr != 0), 1);
      end
      chk("time_busy_cycles", bc, 11);
      chk("time_total", total_time, 10);
      @(negedge clk) enable = 1'b1;
      @(negedge clk) #2 chk("time_restart", total_time, 0);
      @(negedge clk) #2 chk("time_count1", total_time, 1);
      // random traffic
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         enable = $urandom_range(0, 19) != 0;
         clear_counts = $urandom_range(0, 49) == 0;
         rand_in();
      end
      // reset mid-run
      @(negedge clk) enable = 1'b1;
      clear_counts = 1'b0;
      for (int i = 0; i < NP; i++) set_in(i, 1'b1, 2'(i), $urandom);
      repeat (3) @(negedge clk);
      @(posedge clk) #1 chk("mid_pre_wr", 32'(bus.out_ram_wr), 32'hF);
      #1 reset = 1'b1;
      #1;
      chk("mid_wr", 32'(bus.out_ram_wr), 0);
      chk("mid_ready", 32'(bus.in_ready), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_time", total_time, 0);
      chk("mid_outp0", bus.outp[0], 0);
      @(negedge clk) enable = 1'b0;
      reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk) rand_in();
         #2 chk("post_rst_wr", 32'(bus.out_ram_wr), 0);
      end
      @(negedge clk) enable = 1'b1;
      repeat (10) @(negedge clk) rand_in();
      @(negedge clk) begin
         enable = 1'b0;
         idle_in();
      end
      repeat (4) @(negedge clk);
      #3 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
